// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter sharing one registered XOR unit between two req/ack requesters.
// Grant edge -> ack (CAPTURE) -> result registered (COMPUTE) -> done (RESPOND); one op per 4 cycles.
module xor_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             owner,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMPUTE = 2'd2,
    RESPOND = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic [WIDTH-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;

  logic grant_vld;
  logic grant_idx;

  // On a tie the requester that did not win last time gets the unit.
  always_comb begin
    grant_vld = req0 | req1;
    grant_idx = 1'b0;
    if (req0 && req1) begin
      grant_idx = ~last_grant_q;
    end else if (req1) begin
      grant_idx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = CAPTURE;
      CAPTURE: state_d = COMPUTE;
      COMPUTE: state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      cnt_q        <= '0;
    end else begin
      if (state_q == IDLE && grant_vld) begin
        op_a_q       <= grant_idx ? a1 : a0;
        op_b_q       <= grant_idx ? b1 : b0;
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (state_q == COMPUTE) begin
        result_q <= op_a_q ^ op_b_q;
      end
      if (state_q == RESPOND) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    ack0  = (state_q == CAPTURE) && !owner_q;
    ack1  = (state_q == CAPTURE) &&  owner_q;
    done0 = (state_q == RESPOND) && !owner_q;
    done1 = (state_q == RESPOND) &&  owner_q;
    busy  = (state_q != IDLE);
  end

  assign result   = result_q;
  assign owner    = owner_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter; all checks sampled on the falling clock edge.
module tb_xor_unit_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       ack0, ack1, done0, done1, owner, busy;
  logic [7:0] result, op_count;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  xor_unit_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result(result), .owner(owner), .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) for a done pulse; returns who finished, -1 on timeout.
  task automatic wait_done(input string tag, output int who);
    who = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (done0 || done1) begin
        who = done1 ? 1 : 0;
        break;
      end
    end
    if (who < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  int who;
  int ack_overlap;
  int done_seen;

  initial begin
    // Reset state
    tick();
    chk("rst_ack0", ack0, 0);   chk("rst_ack1", ack1, 0);
    chk("rst_done0", done0, 0); chk("rst_done1", done1, 0);
    chk("rst_busy", busy, 0);   chk("rst_owner", owner, 0);
    chk("rst_result", result, 8'h00); chk("rst_cnt", op_count, 8'h00);

    // Single request with exact cycle timing
    do_reset();
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
    tick();
    chk("t1_ack0", ack0, 1); chk("t1_ack1", ack1, 0);
    chk("t1_busy", busy, 1); chk("t1_owner_cap", owner, 0);
    req0 = 1'b0;
    tick();
    chk("t1_done_early", done0, 0);
    tick();
    chk("t1_done0", done0, 1); chk("t1_done1", done1, 0);
    chk("t1_result", result, 8'hAA); chk("t1_owner", owner, 0);
    tick();
    chk("t1_done_len", done0, 0); chk("t1_idle_busy", busy, 0);
    chk("t1_cnt", op_count, 1); chk("t1_result_hold", result, 8'hAA);

    // Simultaneous first request: 0 first, 1 granted 4 cycles later
    do_reset();
    req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
    req1 = 1'b1; a1 = 8'hFF; b1 = 8'h00;
    tick();
    chk("t2_ack0", ack0, 1); chk("t2_ack1", ack1, 0);
    req0 = 1'b0;
    tick(); tick();
    chk("t2_done0", done0, 1); chk("t2_res0", result, 8'h33);
    tick();
    chk("t2_idle", busy, 0);
    tick();
    chk("t2_ack1", ack1, 1); chk("t2_owner1", owner, 1);
    req1 = 1'b0;
    tick(); tick();
    chk("t2_done1", done1, 1); chk("t2_res1", result, 8'hFF);

    // Continuous contention: strict alternation
    do_reset();
    req0 = 1'b1; a0 = 8'h01; b0 = 8'h02;
    req1 = 1'b1; a1 = 8'h10; b1 = 8'h20;
    ack_overlap = 0;
    for (int k = 0; k < 8; k++) begin
      who = -1;
      for (int i = 0; i < 16; i++) begin
        tick();
        if (ack0 && ack1) ack_overlap++;
        if (done0 && done1) ack_overlap++;
        if (done0 || done1) begin
          who = done1 ? 1 : 0;
          break;
        end
      end
      if (who < 0) chk("t3_timeout", 0, 1);
      chk($sformatf("t3_order%0d", k), who, k % 2);
      chk($sformatf("t3_res%0d", k), result, (k % 2) ? 8'h30 : 8'h03);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    chk("t3_cnt", op_count, 8);
    chk("t3_overlap", ack_overlap, 0);

    // Operand change after grant is ignored
    do_reset();
    req0 = 1'b1; a0 = 8'h3C; b0 = 8'hC3;
    tick();
    chk("t4_ack0", ack0, 1);
    a0 = 8'h00; req0 = 1'b0;
    tick(); tick();
    chk("t4_done0", done0, 1); chk("t4_result", result, 8'hFF);

    // Reset in COMPUTE discards the op
    do_reset();
    req0 = 1'b1; a0 = 8'h12; b0 = 8'h34;
    tick();
    chk("t5_ack0", ack0, 1);
    req0 = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("t5_busy", busy, 0);   chk("t5_done0", done0, 0);
    chk("t5_ack0r", ack0, 0);  chk("t5_result", result, 0);
    chk("t5_owner", owner, 0); chk("t5_cnt", op_count, 0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done0 || done1) done_seen++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done0 || done1) done_seen++;
    end
    chk("t5_no_done", done_seen, 0);
    req0 = 1'b1; a0 = 8'hF0; b0 = 8'h0F;
    tick();
    req0 = 1'b0;
    wait_done("t5_after", who);
    chk("t5_who", who, 0); chk("t5_res_after", result, 8'hFF);
    tick();
    chk("t5_cnt_after", op_count, 1);

    // Counter wrap after 256 ops, 257th gives 1
    do_reset();
    req0 = 1'b1; a0 = 8'h55; b0 = 8'hAA;
    for (int k = 0; k < 256; k++) wait_done("t6_loop", who);
    tick();
    chk("t6_wrap", op_count, 0);
    wait_done("t6_257", who);
    req0 = 1'b0;
    tick();
    chk("t6_cnt257", op_count, 1);
    chk("t6_res", result, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xor_unit_arbiter.md
Name: xor_unit_arbiter

Overview:
- Shares one registered WIDTH-bit XOR compute unit between two requesters.
- Arbitration is round-robin.
- Each requester uses a req/ack handshake and gets back a registered result with a one-cycle done pulse.
- Sits between the lab's operand sources (switch/FSM front ends) and the XOR datapath, so the datapath can be time-multiplexed.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CNT_W, 8, width of the completed-operation counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request; held high with operands stable until ack0.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request; same rules as req0.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- ack0  output  1  one-cycle pulse: requester 0 operands captured.
- ack1  output  1  one-cycle pulse: requester 1 operands captured.
- done0  output  1  one-cycle pulse: result valid for requester 0.
- done1  output  1  one-cycle pulse: result valid for requester 1.
- result  output  WIDTH  last computed A^B; holds until the next completion.
- owner  output  1  requester index of the current or last operation.
- busy  output  1  high whenever the FSM is not in IDLE.
- op_count  output  CNT_W  number of completed operations, wrapping.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE.
  - ack0, ack1, done0, done1, busy, owner, result and op_count all become 0.
  - Internal last_grant is set to 1, so requester 0 wins the first tie.
  - Any in-flight operation is discarded and no done pulse is issued for it.
- FSM states: IDLE -> CAPTURE -> COMPUTE -> RESPOND -> IDLE.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On the grant edge: latch the granted a/b into internal op registers, set owner and last_grant to the granted index, go to CAPTURE.
- CAPTURE (1 cycle):
  - ack[owner]=1 and busy=1.
  - The requester must deassert req on the cycle after it sees ack. A req still high in RESPOND/IDLE is treated as a new request.
  - Go to COMPUTE.
- COMPUTE (1 cycle):
  - result <= opA ^ opB, registered.
  - Go to RESPOND.
- RESPOND (1 cycle):
  - done[owner]=1 and result is valid.
  - op_count increments, wrapping from 2^CNT_W-1 to 0.
  - Go to IDLE.
- Timing and throughput:
  - Latency from the grant edge to the done pulse is 3 cycles.
  - Peak throughput is one operation per 4 cycles.
  - IDLE may grant on the edge leaving RESPOND-cycle+1; back-to-back service is therefore 4 cycles apart.
- Operand capture: a/b changes after the grant edge do not affect the result.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1...
- Invariants:
  - ack0/ack1 are never high together; done0/done1 are never high together.
  - busy is low only in IDLE.
- A req arriving while busy is not lost. It is evaluated in the next IDLE cycle, provided the requester holds it.
- result and owner keep their last values in IDLE.

Test Plan:
- Reset then single request:
  - Stimulus: req0=1, a0=8'hA5, b0=8'h0F.
  - Response: ack0 pulses 1 cycle after grant; done0 pulses 3 cycles after grant; result=8'hAA; owner=0; op_count=1; done1/ack1 stay 0.
- Simultaneous first request:
  - Stimulus: req0 and req1 high together after reset, with a1=8'hFF, b1=8'h00.
  - Response: requester 0 is served first. Requester 1 is served next, with result=8'hFF and owner=1, 4 cycles after the first grant.
- Continuous contention:
  - Stimulus: both reqs held high for 8 operations.
  - Response: grant order 0,1,0,1,0,1,0,1; op_count=8; ack and done never overlap between requesters.
- Operand change after grant:
  - Stimulus: a0=8'h3C, b0=8'hC3 at grant, then a0 changed to 8'h00 in CAPTURE.
  - Response: result=8'hFF.
- Reset mid-operation:
  - Stimulus: assert reset during COMPUTE.
  - Response: all outputs 0 immediately with no done pulse. After release, the next request is served normally and op_count counts from 0.
- Counter wrap:
  - Stimulus: 256 completed operations with CNT_W=8.
  - Response: op_count returns to 0; the 257th operation gives op_count=1.
